// File: rtl/roundrobin_pkg.sv
// Shared constants and helpers for the round-robin routing path.
package roundrobin_pkg;

   localparam int DATA_W    = 10;
   localparam int DEST_MSB  = DATA_W - 1;
   localparam int DEST_LSB  = DATA_W - 2;
   localparam int NUM_DEST  = 4;
   localparam int BUF_DEPTH = 2;
   localparam int OCC_W     = 2;

   typedef logic [DEST_MSB-DEST_LSB:0] dest_t;

   // One-hot push vector for a destination index.
   function automatic logic [NUM_DEST-1:0] dest_onehot(input dest_t d);
      logic [NUM_DEST-1:0] oh;
      oh    = '0;
      oh[d] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/buffer_2x.sv
// Two-entry synchronous FIFO holding words waiting for their output FIFO.
module buffer_2x
   import roundrobin_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              wr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd,
   output logic [OCC_W-1:0]  occ,
   output logic [DATA_W-1:0] head
);

   logic [DATA_W-1:0] mem [BUF_DEPTH];
   logic              wr_ptr;
   logic              rd_ptr;

   assign head = mem[rd_ptr];

   // Storage write; a write at full occupancy only happens alongside a read,
   // and the slot being overwritten is the one whose word leaves this edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem[0] <= '0;
         mem[1] <= '0;
      end else if (wr) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         occ    <= '0;
      end else begin
         if (wr) wr_ptr <= ~wr_ptr;
         if (rd) rd_ptr <= ~rd_ptr;
         case ({wr, rd})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

endmodule

// File: rtl/demux_destino.sv
// Routes buffered words to output FIFO P0..P3 by destination field, with
// head-of-line blocking and a stall back to the arbiter.
module demux_destino
   import roundrobin_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_in,
   input  logic [DATA_W-1:0] data_in,
   input  logic              almost_full_P0,
   input  logic              almost_full_P1,
   input  logic              almost_full_P2,
   input  logic              almost_full_P3,
   output logic              push_P0,
   output logic              push_P1,
   output logic              push_P2,
   output logic              push_P3,
   output logic [DATA_W-1:0] data_out,
   output logic              stall,
   output logic              overflow_err
);

   logic [OCC_W-1:0]    occ;
   logic [DATA_W-1:0]   head;
   logic [NUM_DEST-1:0] almost_full;
   logic [NUM_DEST-1:0] push_q;
   dest_t               dest;
   logic                not_empty;
   logic                blocked;
   logic                drain;
   logic                accept;

   buffer_2x u_buffer (
      .clk     (clk),
      .reset   (reset),
      .wr      (accept),
      .wr_data (data_in),
      .rd      (drain),
      .occ     (occ),
      .head    (head)
   );

   assign almost_full = {almost_full_P3, almost_full_P2, almost_full_P1, almost_full_P0};

   // Only the head's destination backpressure matters; a word can leave and
   // another enter in the same cycle even when the buffer is full.
   always_comb begin
      dest      = head[DEST_MSB:DEST_LSB];
      not_empty = (occ != '0);
      blocked   = not_empty && almost_full[dest];
      drain     = not_empty && !blocked;
      accept    = valid_in && ((occ < OCC_W'(BUF_DEPTH)) || drain);
      stall     = (occ == OCC_W'(BUF_DEPTH)) || ((occ == OCC_W'(1)) && blocked);
   end

   // Registered push strobe and shared data word; data holds when idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         push_q   <= '0;
         data_out <= '0;
      end else if (drain) begin
         push_q   <= dest_onehot(dest);
         data_out <= head;
      end else begin
         push_q   <= '0;
      end
   end

   // Sticky error for a word that arrived with no slot to land in.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow_err <= 1'b0;
      end else if (valid_in && !accept) begin
         overflow_err <= 1'b1;
      end
   end

   assign push_P0 = push_q[0];
   assign push_P1 = push_q[1];
   assign push_P2 = push_q[2];
   assign push_P3 = push_q[3];

endmodule

// File: tb/tb_demux_destino.sv
// Directed self-checking bench for demux_destino.
module tb_demux_destino;

   logic       clk = 1'b0;
   logic       reset;
   logic       valid_in;
   logic [9:0] data_in;
   logic [3:0] af;
   logic       push_P0, push_P1, push_P2, push_P3;
   logic [9:0] data_out;
   logic       stall;
   logic       overflow_err;

   int checks   = 0;
   int failures = 0;

   demux_destino dut (
      .clk            (clk),
      .reset          (reset),
      .valid_in       (valid_in),
      .data_in        (data_in),
      .almost_full_P0 (af[0]),
      .almost_full_P1 (af[1]),
      .almost_full_P2 (af[2]),
      .almost_full_P3 (af[3]),
      .push_P0        (push_P0),
      .push_P1        (push_P1),
      .push_P2        (push_P2),
      .push_P3        (push_P3),
      .data_out       (data_out),
      .stall          (stall),
      .overflow_err   (overflow_err)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Drive one cycle of input at the falling edge, then return at the next falling edge.
   task automatic applyStimulus(input logic v, input logic [9:0] d);
      valid_in = v;
      data_in  = d;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Compare {push_P3..P0, data_out, stall, overflow_err} with the expected tuple.
   task automatic checkOutput(input string tag, input logic [3:0] exp_push,
                              input logic [9:0] exp_data, input logic exp_stall,
                              input logic exp_ovf);
      logic [15:0] obs;
      logic [15:0] exp;
      obs = {push_P3, push_P2, push_P1, push_P0, data_out, stall, overflow_err};
      exp = {exp_push, exp_data, exp_stall, exp_ovf};
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s: push=%b data=%h stall=%b ovf=%b, expected push=%b data=%h stall=%b ovf=%b",
                tag, obs[15:12], obs[11:2], obs[1], obs[0],
                exp[15:12], exp[11:2], exp[1], exp[0]);
      end
   endtask

   initial begin
      reset    = 1'b1;
      valid_in = 1'b0;
      data_in  = '0;
      af       = '0;
      #1;
      checkOutput("reset_state", 4'b0000, 10'h000, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;

      // Single word to P2
      applyStimulus(1'b1, 10'h2A5);
      checkOutput("single_accept", 4'b0000, 10'h000, 1'b0, 1'b0);
      applyStimulus(1'b0, 10'h000);
      checkOutput("single_push", 4'b0100, 10'h2A5, 1'b0, 1'b0);
      applyStimulus(1'b0, 10'h000);
      checkOutput("single_done", 4'b0000, 10'h2A5, 1'b0, 1'b0);

      // Back-to-back, one per destination
      applyStimulus(1'b1, 10'h011);
      checkOutput("b2b_first_in", 4'b0000, 10'h2A5, 1'b0, 1'b0);
      applyStimulus(1'b1, 10'h122);
      checkOutput("b2b_p0", 4'b0001, 10'h011, 1'b0, 1'b0);
      applyStimulus(1'b1, 10'h233);
      checkOutput("b2b_p1", 4'b0010, 10'h122, 1'b0, 1'b0);
      applyStimulus(1'b1, 10'h344);
      checkOutput("b2b_p2", 4'b0100, 10'h233, 1'b0, 1'b0);
      applyStimulus(1'b0, 10'h000);
      checkOutput("b2b_p3", 4'b1000, 10'h344, 1'b0, 1'b0);
      applyStimulus(1'b0, 10'h000);
      checkOutput("b2b_idle", 4'b0000, 10'h344, 1'b0, 1'b0);

      // Backpressure on P1 with a P0 word queued behind it
      af = 4'b0010;
      applyStimulus(1'b1, 10'h155);
      checkOutput("bp_head_blocked", 4'b0000, 10'h344, 1'b1, 1'b0);
      applyStimulus(1'b1, 10'h066);
      checkOutput("bp_full", 4'b0000, 10'h344, 1'b1, 1'b0);
      applyStimulus(1'b0, 10'h000);
      checkOutput("bp_hold", 4'b0000, 10'h344, 1'b1, 1'b0);
      af = 4'b0000;
      #1;
      checkOutput("bp_release_full_stall", 4'b0000, 10'h344, 1'b1, 1'b0);
      applyStimulus(1'b0, 10'h000);
      checkOutput("bp_push_p1", 4'b0010, 10'h155, 1'b0, 1'b0);
      applyStimulus(1'b0, 10'h000);
      checkOutput("bp_push_p0", 4'b0001, 10'h066, 1'b0, 1'b0);
      applyStimulus(1'b0, 10'h000);
      checkOutput("bp_idle", 4'b0000, 10'h066, 1'b0, 1'b0);

      // Overflow: third word while full and blocked
      af = 4'b0010;
      applyStimulus(1'b1, 10'h155);
      checkOutput("ovf_fill1", 4'b0000, 10'h066, 1'b1, 1'b0);
      applyStimulus(1'b1, 10'h066);
      checkOutput("ovf_fill2", 4'b0000, 10'h066, 1'b1, 1'b0);
      applyStimulus(1'b1, 10'h377);
      checkOutput("ovf_set", 4'b0000, 10'h066, 1'b1, 1'b1);
      applyStimulus(1'b0, 10'h000);
      checkOutput("ovf_sticky", 4'b0000, 10'h066, 1'b1, 1'b1);
      af = 4'b0000;
      applyStimulus(1'b0, 10'h000);
      checkOutput("ovf_drain_p1", 4'b0010, 10'h155, 1'b0, 1'b1);
      applyStimulus(1'b0, 10'h000);
      checkOutput("ovf_drain_p0", 4'b0001, 10'h066, 1'b0, 1'b1);
      applyStimulus(1'b0, 10'h000);
      checkOutput("ovf_dropped", 4'b0000, 10'h066, 1'b0, 1'b1);

      // Reset mid-flight with a full buffer
      af = 4'b0010;
      applyStimulus(1'b1, 10'h155);
      applyStimulus(1'b1, 10'h066);
      checkOutput("rst_pre_full", 4'b0000, 10'h066, 1'b1, 1'b1);
      valid_in = 1'b0;
      #2 reset = 1'b1;
      #1;
      checkOutput("rst_async_full", 4'b0000, 10'h000, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      af    = 4'b0000;
      applyStimulus(1'b0, 10'h000);
      checkOutput("rst_no_stale1", 4'b0000, 10'h000, 1'b0, 1'b0);
      applyStimulus(1'b0, 10'h000);
      checkOutput("rst_no_stale2", 4'b0000, 10'h000, 1'b0, 1'b0);

      // Reset while a push strobe is high
      applyStimulus(1'b1, 10'h2A5);
      applyStimulus(1'b0, 10'h000);
      checkOutput("rst_pre_push", 4'b0100, 10'h2A5, 1'b0, 1'b0);
      #2 reset = 1'b1;
      #1;
      checkOutput("rst_async_push", 4'b0000, 10'h000, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(1'b0, 10'h000);
      checkOutput("rst_push_gone", 4'b0000, 10'h000, 1'b0, 1'b0);

      // Simultaneous accept and drain at full occupancy
      af = 4'b0010;
      applyStimulus(1'b1, 10'h155);
      applyStimulus(1'b1, 10'h066);
      checkOutput("sim_full", 4'b0000, 10'h000, 1'b1, 1'b0);
      af = 4'b0000;
      applyStimulus(1'b1, 10'h311);
      checkOutput("sim_accept_drain", 4'b0010, 10'h155, 1'b1, 1'b0);
      applyStimulus(1'b0, 10'h000);
      checkOutput("sim_p0", 4'b0001, 10'h066, 1'b0, 1'b0);
      applyStimulus(1'b0, 10'h000);
      checkOutput("sim_p3", 4'b1000, 10'h311, 1'b0, 1'b0);
      applyStimulus(1'b0, 10'h000);
      checkOutput("sim_idle", 4'b0000, 10'h311, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/demux_destino.md
# demux_destino

Routing stage between the round-robin arbiter and the four output FIFOs P0–P3. Accepts the 10-bit word popped from the arbiter-selected input FIFO, decodes the destination from bits [9:8] and pushes it into the matching output FIFO, one word per cycle. It holds up to two words in a small buffer and asserts `stall` back to the arbiter when it cannot absorb further pops, so no word is lost while an output FIFO is almost full.

## Interface
- `DATA_W`, 10, word width; bits [DATA_W-1:DATA_W-2] are the destination, the rest is payload
- `clk`  in  1  single clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `valid_in`  in  1  `data_in` carries a popped word this cycle (the arbiter's pop, delayed one cycle by the FIFO read)
- `data_in`  in  DATA_W  word from the input FIFO
- `almost_full_P0`..`almost_full_P3`  in  1 each  output-FIFO backpressure
- `push_P0`..`push_P3`  out  1 each  registered push strobe, at most one high per cycle
- `data_out`  out  DATA_W  registered word shared by all four output FIFOs, valid while any `push_Px` is high
- `stall`  out  1  combinational from registered state; the arbiter must not pop while high
- `overflow_err`  out  1  sticky; set when a word arrives with no free buffer slot

## Operation
- The buffer is a 2-entry FIFO: `head`, `tail`, `occ` in 0..2. `dest` = head[9:8].
- `blocked` = (occ != 0) && almost_full_P[dest].
- `drain` = (occ != 0) && !blocked.
- Each edge:
  - On `drain`, pop the head; next cycle push_P[dest]=1 and data_out=head.
  - With no drain, all `push_Px` are 0 next cycle and `data_out` holds its last value.
  - On `valid_in`, write `data_in` to the tail when occ<2, or when occ==2 and `drain` is true in the same cycle.
  - Otherwise the word is dropped and `overflow_err` is set until reset.
- `occ` next = occ + accept − drain.
- `stall` = (occ==2) || (occ==1 && blocked). Because of the one-cycle pop-to-valid latency, a word already in flight when `stall` rises always finds a free slot. Overflow only occurs if the upstream ignores `stall`.
- Words leave in arrival order. Head-of-line blocking is intended: a blocked head blocks later words for other destinations.
- `almost_full` is sampled only for the head's destination; the other three are ignored.
- Reset values: push_P0..3=0, data_out=0, stall=0, overflow_err=0, occ=0. Reset mid-operation discards buffered words. Pushes already registered are cleared immediately.

## Timing
- Latency: `valid_in` sampled at edge E0 with occ=0 and destination not almost full → push visible after edge E1. Minimum latency is 2 edges.
- Throughput: 1 word/cycle sustained when destinations are not almost full.
- Release: `almost_full` falling at cycle t (head blocked) → drain at edge t → push visible after that edge.
- `stall` reacts in the same cycle `occ` or the head's `almost_full` changes. No registered delay.

## Structure
- Shared package (`roundrobin_pkg`), holding:
  - `DATA_W`
  - destination field position `DEST_MSB` / `DEST_LSB`
  - `NUM_DEST` = 4
  - `BUF_DEPTH` = 2
- One sub-module, `buffer_2x`: the 2-entry synchronous FIFO with `wr`, `rd`, `occ`, `head` and async reset. The top level holds the destination decode, push/data registers, `stall` logic and the error flag.

## Test plan
- **Reset mid-flight:** assert `reset` with occ=2 → push_P0..3=0, stall=0, occ=0 asynchronously; no stale push after release.
- **Single word, free path:** data_in=10'h2A5 (dest 2), all almost_full=0 → push_P2=1 with data_out=10'h2A5 for exactly one cycle, 2 edges after sampling.
- **Back-to-back, all destinations:** words 10'h011, 10'h122, 10'h233, 10'h344 → push_P0..push_P3 on four consecutive cycles, in order; stall stays 0.
- **Backpressure:** almost_full_P1=1; send 10'h155, then 10'h066.
  - Required: no push; occ reaches 2; stall=1; 10'h066 waits behind the blocked head.
  - Release almost_full_P1 → push_P1 with 10'h155, then push_P0 with 10'h066 on the next cycle.
- **Overflow:** force occ=2 with the head blocked; drive valid_in=1 with 10'h377 → overflow_err=1 and stays 1; the buffered words are unchanged and later drain normally.
- **Simultaneous accept and drain at occ=2:** release almost_full on the same cycle a word arrives → word accepted, overflow_err stays 0, occ stays 2.
